// File: rtl/data_mem_arbiter.sv
// Shares the single-cycle data_mem between the core port (C) and the debug port (D).
// D may run locked address-incrementing bursts; C is single-beat only.
module data_mem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST = 8,
    localparam int LW = $clog2(MAX_BURST) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_req,
    input  logic [2:0]               c_re,
    input  logic [3:0]               c_we,
    input  logic [ADDRESS_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0]    c_wdata,
    output logic                     c_gnt,
    output logic                     c_stall,
    output logic [DATA_WIDTH-1:0]    c_rdata,
    output logic                     c_rvalid,
    input  logic                     d_req,
    input  logic [2:0]               d_re,
    input  logic [3:0]               d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    input  logic [LW-1:0]            d_len,
    output logic                     d_gnt,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_rvalid,
    output logic                     d_done,
    output logic [2:0]               mem_re,
    output logic [3:0]               mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    typedef enum logic {ARB, BURST} state_t;

    state_t                   state;
    state_t                   state_n;
    logic                     prio;
    logic [LW-1:0]            cnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [2:0]               re_q;
    logic [3:0]               we_q;
    logic [LW-1:0]            eff_len;
    logic                     single;
    logic                     last;

    // d_len of 0 means one beat; anything above MAX_BURST is clamped
    always_comb begin
        if (d_len == '0)
            eff_len = LW'(1);
        else if (d_len > LW'(MAX_BURST))
            eff_len = LW'(MAX_BURST);
        else
            eff_len = d_len;
    end

    assign single = (eff_len == LW'(1));
    assign last   = (cnt == LW'(1));

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ARB;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARB:     if (d_gnt && !single) state_n = BURST;
            BURST:   if (!d_req || last) state_n = ARB;
            default: state_n = ARB;
        endcase
    end

    always_comb begin
        c_gnt  = 1'b0;
        d_gnt  = 1'b0;
        mem_re = 3'b000;
        mem_we = 4'b0000;
        mem_a  = c_addr;
        mem_wd = c_wdata;
        if (rst) begin
            unique case (state)
                ARB: begin
                    c_gnt = c_req && (!d_req || !prio);
                    d_gnt = d_req && (!c_req || prio);
                end
                BURST:   d_gnt = d_req;
                default: ;
            endcase
        end
        if (d_gnt) begin
            mem_re = (state == BURST) ? re_q : d_re;
            mem_we = (state == BURST) ? we_q : d_we;
            mem_a  = (state == BURST) ? addr_q : d_addr;
            mem_wd = d_wdata;
        end else if (c_gnt) begin
            mem_re = c_re;
            mem_we = c_we;
        end
    end

    assign c_stall = c_req & ~c_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prio     <= 1'b0;
            cnt      <= '0;
            addr_q   <= '0;
            re_q     <= 3'b000;
            we_q     <= 4'b0000;
            c_rdata  <= '0;
            c_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_rvalid <= 1'b0;
            d_done   <= 1'b0;
        end else begin
            c_rvalid <= c_gnt && (c_re != 3'b000);
            d_rvalid <= d_gnt && (mem_re != 3'b000);
            d_done   <= 1'b0;
            if (c_gnt && (c_re != 3'b000))
                c_rdata <= mem_rd;
            if (d_gnt && (mem_re != 3'b000))
                d_rdata <= mem_rd;
            if (c_gnt)
                prio <= 1'b1;
            if (state == ARB && d_gnt) begin
                if (single) begin
                    prio   <= 1'b0;
                    d_done <= 1'b1;
                end else begin
                    cnt    <= eff_len - LW'(1);
                    addr_q <= d_addr + ADDRESS_WIDTH'(4);
                    re_q   <= d_re;
                    we_q   <= d_we;
                end
            end else if (state == BURST) begin
                if (d_gnt) begin
                    cnt    <= cnt - LW'(1);
                    addr_q <= addr_q + ADDRESS_WIDTH'(4);
                    if (last) begin
                        prio   <= 1'b0;
                        d_done <= 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and burst sequencer that shares the single-cycle `data_mem` between the core's load/store port (port C) and a debug/program-loader port (port D). Each cycle it grants at most one requester and drives the memory's `RE`/`WE`/`A`/write-data inputs from the winner. It also registers read data back to the owner and provides a stall indication for the core. Port D may issue locked, address-incrementing bursts; port C is single-beat only.

## Interface
- `ADDRESS_WIDTH`, 32: address width, all ports.
- `DATA_WIDTH`, 32: data width, all ports.
- `MAX_BURST`, 8: maximum port-D burst length in beats.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `c_req` in 1: core requests one access this cycle.
- `c_re` in 3 / `c_we` in 4: core read-type code / byte write enables, passed to memory.
- `c_addr` in ADDRESS_WIDTH, `c_wdata` in DATA_WIDTH: core address / write data.
- `c_gnt` out 1: core access performed this cycle.
- `c_stall` out 1: `c_req & ~c_gnt`.
- `c_rdata` out DATA_WIDTH, `c_rvalid` out 1: registered read data for core.
- `d_req` in 1, `d_re` in 3, `d_we` in 4, `d_addr` in ADDRESS_WIDTH, `d_wdata` in DATA_WIDTH: debug request, read code, write enables, start address, beat data.
- `d_len` in clog2(MAX_BURST)+1: burst length in beats, sampled on first grant.
- `d_gnt` out 1, `d_rdata` out DATA_WIDTH, `d_rvalid` out 1, `d_done` out 1: debug grant, read data, read valid, burst-complete pulse.
- `mem_re` out 3, `mem_we` out 4, `mem_a` out ADDRESS_WIDTH, `mem_wd` out DATA_WIDTH: to `data_mem`.
- `mem_rd` in DATA_WIDTH: combinational read data from `data_mem`.

## Operation
- State machine states: ARB and BURST. Priority bit `prio` (0 = core favoured, 1 = debug favoured).
- ARB:
  - Only `c_req` high: grant C.
  - Only `d_req` high: grant D.
  - Both high: grant the port favoured by `prio`.
  - Neither high: no grant; `mem_re` = 0 and `mem_we` = 0.
- `prio` update:
  - Any C grant sets `prio` = 1.
  - A D single-beat grant, or the final beat of a D burst, sets `prio` = 0.
- Burst entry: D is granted in ARB with effective length L > 1.
  - Effective length L = `d_len`, except `d_len` = 0 is treated as 1 and `d_len` > MAX_BURST is clamped to MAX_BURST.
  - On entry, latch `d_re`/`d_we`, set the next address to `d_addr` + 4 and the remaining-beat count to L−1, then go to BURST.
- BURST:
  - C is never granted; `c_stall` follows `c_req`.
  - While `d_req` is high: grant D, drive `mem_a` = the internal address, use the latched `re`/`we` and the current `d_wdata`, post-increment the address by 4, and decrement the count.
  - When the count reaches 0 on a granted beat: return to ARB and set `prio` = 0.
  - `d_req` low in BURST: abort. Return to ARB, no grant that cycle, `d_done` not asserted.
- Address increment wraps modulo 2^ADDRESS_WIDTH (0xFFFFFFFC + 4 = 0x00000000).
- `d_done` pulses after the final beat of a burst or after a single-beat D access. It never pulses on abort.
- The memory-side mux is driven only by the current grant. With no grant, `mem_a` and `mem_wd` hold the port-C values and the enables are 0.

## Timing
- Grant is combinational in the request cycle: `c_gnt`/`d_gnt` and the `mem_*` outputs are valid in the same cycle as `req`. Writes commit at the following rising edge.
- Read data for a granted access with nonzero `re`: `mem_rd` is captured into `x_rdata` at the edge ending the grant cycle, and `x_rvalid` is high for exactly the next cycle. Latency 1.
- `d_done` is registered: high for the one cycle after the final beat's grant, coincident with that beat's `d_rvalid`.
- Burst throughput: 1 beat per cycle. Worst-case core wait is MAX_BURST cycles plus 1 contention cycle.
- Reset (`rst` = 0 at an edge) forces:
  - state = ARB, `prio` = 0, beat count = 0;
  - `c_rvalid`, `d_rvalid`, `d_done` = 0;
  - `c_rdata`, `d_rdata` = 0.
  - Combinational grants are also forced to 0 while `rst` = 0.
- Reset mid-burst abandons the burst: no `d_done`, no further beats. Writes already committed remain.
- Requests presented in the reset-release cycle are arbitrated normally.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `c_req` = `d_req` = 1 -> no grants, `mem_we` = 0, all registered outputs 0.
- Core only: read at 0x10 with `mem_rd` = 0xDEADBEEF -> `c_gnt` = 1 in the same cycle, `c_rvalid` = 1 and `c_rdata` = 0xDEADBEEF one cycle later.
- Contention: `c_req` and `d_req` single-beat held for 4 cycles from reset -> grant order C, D, C, D; `c_stall` = 1 in the D cycles; `d_done` pulses after each D grant.
- Burst write: `d_len` = 4, `d_addr` = 0x100, `d_we` = 0xF, `c_req` = 1 throughout -> `mem_a` = 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles; `c_gnt` = 0 for all 4; `d_done` in cycle 5; C granted in cycle 5.
- Abort: `d_len` = 4, `d_req` dropped after beat 2 -> return to ARB, C granted next cycle, `d_done` never asserted, `prio` unchanged.
- Wrap and clamp: `d_len` = 15 with MAX_BURST = 8 at `d_addr` = 0xFFFFFFF8 -> exactly 8 beats at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, … 0x14; also `d_len` = 0 -> 1 beat.
